// File: rtl/token_emitter.sv
// token_emitter
//
// Token-to-character serializer. Accepts typed tokens (kind plus optional
// text payload) and produces the equivalent ASCII source text, one byte per
// handshake. Indentation is regenerated from indent/dedent tokens as four
// spaces per level at the start of each line. Tokens on the same line are
// separated by a single space.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   tok_valid  token present
//   tok_ready  token accepted when tok_valid && tok_ready (only in IDLE)
//   tok_kind   5-bit token kind code
//   tok_len    payload byte count (name/int/float only)
//   tok_text   payload bytes, byte 0 in [7:0] is emitted first
//   out_valid  output byte present
//   out_ready  output byte consumed when out_valid && out_ready
//   out_data   ASCII byte
//   done       one-cycle pulse when eof processing completes
//   err        sticky error flag, cleared only by reset
//   depth      current indentation level
module token_emitter #(
    parameter int MAX_LEN   = 16,
    parameter int MAX_DEPTH = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tok_valid,
    output logic                           tok_ready,
    input  logic [4:0]                     tok_kind,
    input  logic [$clog2(MAX_LEN+1)-1:0]   tok_len,
    input  logic [8*MAX_LEN-1:0]           tok_text,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_data,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int TW = 8 * MAX_LEN;
    // Space counter must hold 4*level
    localparam int SW = DW + 2;

    localparam logic [4:0] K_EOF     = 5'd0;
    localparam logic [4:0] K_NEWLINE = 5'd1;
    localparam logic [4:0] K_INDENT  = 5'd2;
    localparam logic [4:0] K_DEDENT  = 5'd3;
    localparam logic [4:0] K_PLUS    = 5'd4;
    localparam logic [4:0] K_NAME    = 5'd14;
    localparam logic [4:0] K_INT     = 5'd15;
    localparam logic [4:0] K_FLOAT   = 5'd16;
    localparam logic [4:0] K_OR      = 5'd22;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_NL     = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INDENT = 3'd1,
        ST_SEP    = 3'd2,
        ST_BODY   = 3'd3,
        ST_EOL    = 3'd4
    } state_t;

    // Fixed text of operator and keyword tokens, byte 0 in [7:0]
    function automatic logic [39:0] rom_text(input logic [4:0] kind);
        logic [39:0] t;
        case (kind)
            5'd4:    t = 40'h00_00_00_00_2B;       // +
            5'd5:    t = 40'h00_00_00_00_2D;       // -
            5'd6:    t = 40'h00_00_00_00_2A;       // *
            5'd7:    t = 40'h00_00_00_00_2F;       // /
            5'd8:    t = 40'h00_00_00_00_25;       // %
            5'd9:    t = 40'h00_00_00_00_28;       // (
            5'd10:   t = 40'h00_00_00_00_29;       // )
            5'd11:   t = 40'h00_00_00_00_3D;       // =
            5'd12:   t = 40'h00_00_00_00_3A;       // :
            5'd13:   t = 40'h00_00_00_2A_2A;       // **
            5'd17:   t = 40'h00_00_00_66_69;       // if
            5'd18:   t = 40'h00_65_75_72_74;       // true
            5'd19:   t = 40'h65_73_6C_61_66;       // false
            5'd20:   t = 40'h00_00_74_6F_6E;       // not
            5'd21:   t = 40'h00_00_64_6E_61;       // and
            5'd22:   t = 40'h00_00_00_72_6F;       // or
            default: t = 40'h00_00_00_00_00;
        endcase
        return t;
    endfunction

    // Byte count of operator and keyword tokens
    function automatic logic [2:0] rom_len(input logic [4:0] kind);
        logic [2:0] n;
        case (kind)
            5'd13, 5'd17, 5'd22: n = 3'd2;
            5'd20, 5'd21:        n = 3'd3;
            5'd18:               n = 3'd4;
            5'd19:               n = 3'd5;
            default:             n = 3'd1;
        endcase
        return n;
    endfunction

    state_t          state_r, state_s;
    logic            tok_ready_r, tok_ready_s;
    logic            out_valid_r, out_valid_s;
    logic [7:0]      out_data_r, out_data_s;
    logic            done_r, done_s;
    logic            err_r, err_s;
    logic            bol_r, bol_s;
    logic [DW-1:0]   level_r, level_s;
    logic [TW-1:0]   text_r, text_s;
    logic [LW-1:0]   len_r, len_s;
    logic [LW-1:0]   idx_r, idx_s;
    logic [SW-1:0]   spc_r, spc_s;
    logic            eof_r, eof_s;
    logic            hs_s;
    logic            content_s;
    logic [TW-1:0]   ctext_s;
    logic [LW-1:0]   clen_s;

    assign tok_ready = tok_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign done      = done_r;
    assign err       = err_r;
    assign depth     = level_r;

    // Next-state, datapath and output computation for the emitter FSM
    always_comb begin
        state_s     = state_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        done_s      = 1'b0;
        err_s       = err_r;
        bol_s       = bol_r;
        level_s     = level_r;
        text_s      = text_r;
        len_s       = len_r;
        idx_s       = idx_r;
        spc_s       = spc_r;
        eof_s       = eof_r;
        content_s   = 1'b0;
        ctext_s     = '0;
        clen_s      = '0;
        hs_s        = out_valid_r && out_ready;

        case (state_r)
            ST_IDLE: begin
                if (tok_valid && tok_ready_r) begin
                    case (tok_kind)
                        K_EOF: begin
                            if (bol_r) begin
                                // Nothing to terminate: finish on acceptance
                                done_s  = 1'b1;
                                level_s = '0;
                            end else begin
                                state_s     = ST_EOL;
                                eof_s       = 1'b1;
                                out_valid_s = 1'b1;
                                out_data_s  = CH_NL;
                            end
                        end
                        K_NEWLINE: begin
                            state_s     = ST_EOL;
                            eof_s       = 1'b0;
                            out_valid_s = 1'b1;
                            out_data_s  = CH_NL;
                            bol_s       = 1'b1;
                        end
                        K_INDENT: begin
                            if (level_r == DW'(MAX_DEPTH)) begin
                                err_s = 1'b1;
                            end else begin
                                level_s = level_r + 1'b1;
                            end
                        end
                        K_DEDENT: begin
                            if (level_r == '0) begin
                                err_s = 1'b1;
                            end else begin
                                level_s = level_r - 1'b1;
                            end
                        end
                        K_NAME, K_INT, K_FLOAT: begin
                            if (tok_len != '0 && tok_len <= LW'(MAX_LEN)) begin
                                content_s = 1'b1;
                                ctext_s   = tok_text;
                                clen_s    = tok_len;
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                        default: begin
                            if (tok_kind >= K_PLUS && tok_kind <= K_OR) begin
                                content_s     = 1'b1;
                                ctext_s[39:0] = rom_text(tok_kind);
                                clen_s        = LW'(rom_len(tok_kind));
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                    endcase

                    // Content tokens: first byte is an indent space,
                    // a separator space, or the first text byte
                    if (content_s) begin
                        text_s      = ctext_s;
                        len_s       = clen_s;
                        out_valid_s = 1'b1;
                        bol_s       = 1'b0;
                        if (bol_r && level_r != '0) begin
                            state_s    = ST_INDENT;
                            out_data_s = CH_SPACE;
                            spc_s      = {level_r, 2'b00} - 1'b1;
                        end else if (bol_r) begin
                            state_s    = ST_BODY;
                            out_data_s = ctext_s[7:0];
                            idx_s      = {{(LW-1){1'b0}}, 1'b1};
                        end else begin
                            state_s    = ST_SEP;
                            out_data_s = CH_SPACE;
                        end
                    end else begin
                        text_s = text_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INDENT: begin
                if (hs_s) begin
                    if (spc_r != '0) begin
                        spc_s      = spc_r - 1'b1;
                        out_data_s = CH_SPACE;
                    end else begin
                        state_s    = ST_BODY;
                        out_data_s = text_r[7:0];
                        idx_s      = {{(LW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_INDENT;
                end
            end
            ST_SEP: begin
                if (hs_s) begin
                    state_s    = ST_BODY;
                    out_data_s = text_r[7:0];
                    idx_s      = {{(LW-1){1'b0}}, 1'b1};
                end else begin
                    state_s = ST_SEP;
                end
            end
            ST_BODY: begin
                if (hs_s) begin
                    if (idx_r == len_r) begin
                        state_s     = ST_IDLE;
                        out_valid_s = 1'b0;
                    end else begin
                        out_data_s = text_r[{idx_r, 3'b000} +: 8];
                        idx_s      = idx_r + 1'b1;
                    end
                end else begin
                    state_s = ST_BODY;
                end
            end
            ST_EOL: begin
                if (hs_s) begin
                    state_s     = ST_IDLE;
                    out_valid_s = 1'b0;
                    if (eof_r) begin
                        done_s  = 1'b1;
                        level_s = '0;
                        bol_s   = 1'b1;
                    end else begin
                        done_s = 1'b0;
                    end
                end else begin
                    state_s = ST_EOL;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                out_valid_s = 1'b0;
            end
        endcase

        tok_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers; reset abandons any token in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tok_ready_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            bol_r       <= 1'b1;
            level_r     <= '0;
            text_r      <= '0;
            len_r       <= '0;
            idx_r       <= '0;
            spc_r       <= '0;
            eof_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            tok_ready_r <= tok_ready_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            done_r      <= done_s;
            err_r       <= err_s;
            bol_r       <= bol_s;
            level_r     <= level_s;
            text_r      <= text_s;
            len_r       <= len_s;
            idx_r       <= idx_s;
            spc_r       <= spc_s;
            eof_r       <= eof_s;
        end
    end

endmodule
